// File: rtl/reaction_trial_sequencer.sv
// rtl/reaction_trial_sequencer.sv - one reaction-time trial: random wait, stimulus, timed response, best score
// The prescaler restarts on entry to WAIT and TIMING so every phase starts on a whole-tick boundary.
module reaction_trial_sequencer #(
  parameter int TICK_DIV         = 50000,
  parameter int MIN_DELAY_MS     = 1000,
  parameter int DELAY_RANGE_BITS = 11,
  parameter int TIMEOUT_MS       = 9999,
  parameter int COUNT_W          = 14
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_button,
  input  logic               stop_button,
  input  logic               clear_best,
  output logic               led,
  output logic               timer_trigger,
  output logic               result_valid,
  output logic               early_fault,
  output logic               timeout,
  output logic               busy,
  output logic [COUNT_W-1:0] elapsed,
  output logic [COUNT_W-1:0] best,
  output logic [2:0]         state
);

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_WAIT    = 3'b001;
  localparam logic [2:0] S_TIMING  = 3'b010;
  localparam logic [2:0] S_DONE    = 3'b011;
  localparam logic [2:0] S_EARLY   = 3'b100;
  localparam logic [2:0] S_TIMEOUT = 3'b101;

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DELAY_W = $clog2(MIN_DELAY_MS + (1 << DELAY_RANGE_BITS)) + 1;

  logic [2:0]         state_q, state_d;
  logic               start_prev, stop_prev;
  logic               start_rise, stop_rise;
  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic [15:0]        lfsr;
  logic               lfsr_fb;
  logic [DELAY_W-1:0] delay_cnt;
  logic [COUNT_W-1:0] elapsed_q, best_q, elapsed_inc;
  logic               enter_wait, enter_timing, enter_done;

  assign start_rise   = start_button & ~start_prev;
  assign stop_rise    = stop_button & ~stop_prev;
  assign tick         = (presc == PRESC_W'(TICK_DIV - 1));
  assign lfsr_fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign elapsed_inc  = elapsed_q + COUNT_W'(1);
  assign enter_wait   = (state_d == S_WAIT)   && (state_q != S_WAIT);
  assign enter_timing = (state_d == S_TIMING) && (state_q != S_TIMING);
  assign enter_done   = (state_d == S_DONE)   && (state_q != S_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_EARLY, S_TIMEOUT: if (start_rise) state_d = S_WAIT;
      S_WAIT: begin
        if (stop_rise)                                   state_d = S_EARLY;
        else if (tick && delay_cnt == DELAY_W'(1))       state_d = S_TIMING;
      end
      S_TIMING: begin
        if (stop_rise)                                   state_d = S_DONE;
        else if (tick && elapsed_inc == COUNT_W'(TIMEOUT_MS)) state_d = S_TIMEOUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    led         = (state_q == S_TIMING);
    early_fault = (state_q == S_EARLY);
    timeout     = (state_q == S_TIMEOUT);
    busy        = (state_q == S_WAIT) || (state_q == S_TIMING);
    elapsed     = elapsed_q;
    best        = best_q;
    state       = state_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_prev    <= 1'b0;
      stop_prev     <= 1'b0;
      presc         <= '0;
      lfsr          <= 16'hACE1;
      delay_cnt     <= '0;
      elapsed_q     <= '0;
      best_q        <= '1;
      timer_trigger <= 1'b0;
      result_valid  <= 1'b0;
    end else begin
      start_prev    <= start_button;
      stop_prev     <= stop_button;
      lfsr          <= {lfsr[14:0], lfsr_fb};
      timer_trigger <= enter_timing;
      result_valid  <= enter_done;

      if (enter_wait || enter_timing || tick) presc <= '0;
      else                                    presc <= presc + PRESC_W'(1);

      if (enter_wait) begin
        delay_cnt <= DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr[DELAY_RANGE_BITS-1:0]);
        elapsed_q <= '0;
      end else begin
        if (state_q == S_WAIT && !stop_rise && tick && delay_cnt != DELAY_W'(1))
          delay_cnt <= delay_cnt - DELAY_W'(1);
        if (state_q == S_TIMING && !stop_rise && tick)
          elapsed_q <= elapsed_inc;
      end

      // A clear on the same edge as a finished trial discards that result.
      if (clear_best)
        best_q <= '1;
      else if (state_q == S_TIMING && stop_rise && elapsed_q < best_q)
        best_q <= elapsed_q;
    end
  end

endmodule
